dram_axi_arbiter: RTL

- Two-master to one-slave AXI4 arbiter sharing the single DRAM AXI port (1-bit ID, 32-bit addr/data) between the core memory path (s0) and the ethernet DMA path (s1).
- Round-robin arbitration runs independently on AR and AW. W beats follow AW grant order. B/R responses are routed back by the downstream ID, and the downstream ID equals the master index.
- Sits in the top-level clock domain, between the requesters and the memory controller AXI slave.

---
 rtl/dram_axi_arbiter.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dram_axi_arbiter.sv
// rtl/dram_axi_arbiter.sv - two-master round-robin AXI4 arbiter onto the shared DRAM port
// AR and AW arbitrate independently; W beats follow AW grant order through a small index FIFO.
module dram_axi_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int W_FIFO_DEPTH = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    s0_aw_valid,
  output logic                    s0_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   s0_aw_addr,
  input  logic [7:0]              s0_aw_len,
  input  logic [2:0]              s0_aw_size,
  input  logic [1:0]              s0_aw_burst,
  input  logic                    s0_aw_lock,
  input  logic [3:0]              s0_aw_cache,
  input  logic [2:0]              s0_aw_prot,
  input  logic                    s0_w_valid,
  output logic                    s0_w_ready,
  input  logic [DATA_WIDTH-1:0]   s0_w_data,
  input  logic [DATA_WIDTH/8-1:0] s0_w_strb,
  input  logic                    s0_w_last,
  output logic                    s0_b_valid,
  input  logic                    s0_b_ready,
  output logic [1:0]              s0_b_resp,
  input  logic                    s0_ar_valid,
  output logic                    s0_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   s0_ar_addr,
  input  logic [7:0]              s0_ar_len,
  input  logic [2:0]              s0_ar_size,
  input  logic [1:0]              s0_ar_burst,
  input  logic                    s0_ar_lock,
  input  logic [3:0]              s0_ar_cache,
  input  logic [2:0]              s0_ar_prot,
  output logic                    s0_r_valid,
  input  logic                    s0_r_ready,
  output logic [DATA_WIDTH-1:0]   s0_r_data,
  output logic [1:0]              s0_r_resp,
  output logic                    s0_r_last,
  input  logic                    s1_aw_valid,
  output logic                    s1_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   s1_aw_addr,
  input  logic [7:0]              s1_aw_len,
  input  logic [2:0]              s1_aw_size,
  input  logic [1:0]              s1_aw_burst,
  input  logic                    s1_aw_lock,
  input  logic [3:0]              s1_aw_cache,
  input  logic [2:0]              s1_aw_prot,
  input  logic                    s1_w_valid,
  output logic                    s1_w_ready,
  input  logic [DATA_WIDTH-1:0]   s1_w_data,
  input  logic [DATA_WIDTH/8-1:0] s1_w_strb,
  input  logic                    s1_w_last,
  output logic                    s1_b_valid,
  input  logic                    s1_b_ready,
  output logic [1:0]              s1_b_resp,
  input  logic                    s1_ar_valid,
  output logic                    s1_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   s1_ar_addr,
  input  logic [7:0]              s1_ar_len,
  input  logic [2:0]              s1_ar_size,
  input  logic [1:0]              s1_ar_burst,
  input  logic                    s1_ar_lock,
  input  logic [3:0]              s1_ar_cache,
  input  logic [2:0]              s1_ar_prot,
  output logic                    s1_r_valid,
  input  logic                    s1_r_ready,
  output logic [DATA_WIDTH-1:0]   s1_r_data,
  output logic [1:0]              s1_r_resp,
  output logic                    s1_r_last,
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  output logic                    m_aw_id,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [7:0]              m_aw_len,
  output logic [2:0]              m_aw_size,
  output logic [1:0]              m_aw_burst,
  output logic                    m_aw_lock,
  output logic [3:0]              m_aw_cache,
  output logic [2:0]              m_aw_prot,
  output logic                    m_w_valid,
  input  logic                    m_w_ready,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  output logic                    m_w_last,
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  input  logic                    m_b_id,
  input  logic [1:0]              m_b_resp,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  output logic                    m_ar_id,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [7:0]              m_ar_len,
  output logic [2:0]              m_ar_size,
  output logic [1:0]              m_ar_burst,
  output logic                    m_ar_lock,
  output logic [3:0]              m_ar_cache,
  output logic [2:0]              m_ar_prot,
  input  logic                    m_r_valid,
  output logic                    m_r_ready,
  input  logic                    m_r_id,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp,
  input  logic                    m_r_last
);

  localparam int PAY_W = ADDR_WIDTH + 21;
  localparam int PW    = $clog2(W_FIFO_DEPTH);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic {AW_IDLE, AW_SEND} aw_state_t;

  // ---------------- read address ----------------
  ar_state_t        ar_state, ar_state_nxt;
  logic             ar_ptr, ar_win, ar_req, ar_grant;
  logic [PAY_W-1:0] ar_pay;

  assign ar_req = s0_ar_valid || s1_ar_valid;
  // Pointer only matters on contention; a lone requester always wins.
  assign ar_win = (s0_ar_valid && s1_ar_valid) ? ar_ptr : s1_ar_valid;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) ar_state <= AR_IDLE;
    else            ar_state <= ar_state_nxt;
  end

  always_comb begin
    ar_state_nxt = ar_state;
    case (ar_state)
      AR_IDLE: if (ar_req) ar_state_nxt = AR_SEND;
      AR_SEND: if (m_ar_ready) ar_state_nxt = AR_IDLE;
    endcase
  end

  always_comb begin
    ar_grant    = i_reset_n && (ar_state == AR_IDLE) && ar_req;
    s0_ar_ready = ar_grant && !ar_win;
    s1_ar_ready = ar_grant && ar_win;
    m_ar_valid  = (ar_state == AR_SEND);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ar_pay  <= '0;
      m_ar_id <= 1'b0;
      ar_ptr  <= 1'b0;
    end else if (ar_grant) begin
      ar_pay  <= ar_win ? {s1_ar_addr, s1_ar_len, s1_ar_size, s1_ar_burst, s1_ar_lock, s1_ar_cache, s1_ar_prot}
                        : {s0_ar_addr, s0_ar_len, s0_ar_size, s0_ar_burst, s0_ar_lock, s0_ar_cache, s0_ar_prot};
      m_ar_id <= ar_win;
      ar_ptr  <= ~ar_win;
    end
  end

  assign {m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock, m_ar_cache, m_ar_prot} = ar_pay;

  // ---------------- write address ----------------
  aw_state_t        aw_state, aw_state_nxt;
  logic             aw_ptr, aw_win, aw_req, aw_grant;
  logic [PAY_W-1:0] aw_pay;
  logic             w_full;

  assign aw_req = s0_aw_valid || s1_aw_valid;
  assign aw_win = (s0_aw_valid && s1_aw_valid) ? aw_ptr : s1_aw_valid;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) aw_state <= AW_IDLE;
    else            aw_state <= aw_state_nxt;
  end

  always_comb begin
    aw_state_nxt = aw_state;
    case (aw_state)
      AW_IDLE: if (aw_req && !w_full) aw_state_nxt = AW_SEND;
      AW_SEND: if (m_aw_ready) aw_state_nxt = AW_IDLE;
    endcase
  end

  always_comb begin
    aw_grant    = i_reset_n && (aw_state == AW_IDLE) && aw_req && !w_full;
    s0_aw_ready = aw_grant && !aw_win;
    s1_aw_ready = aw_grant && aw_win;
    m_aw_valid  = (aw_state == AW_SEND);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      aw_pay  <= '0;
      m_aw_id <= 1'b0;
      aw_ptr  <= 1'b0;
    end else if (aw_grant) begin
      aw_pay  <= aw_win ? {s1_aw_addr, s1_aw_len, s1_aw_size, s1_aw_burst, s1_aw_lock, s1_aw_cache, s1_aw_prot}
                        : {s0_aw_addr, s0_aw_len, s0_aw_size, s0_aw_burst, s0_aw_lock, s0_aw_cache, s0_aw_prot};
      m_aw_id <= aw_win;
      aw_ptr  <= ~aw_win;
    end
  end

  assign {m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock, m_aw_cache, m_aw_prot} = aw_pay;

  // ---------------- W routing: FIFO of granted master indices ----------------
  logic [W_FIFO_DEPTH-1:0] w_fifo;
  logic [PW-1:0]           w_wr_ptr, w_rd_ptr;
  logic [PW:0]             w_count;
  logic                    w_empty, w_head, w_pop;

  assign w_full  = (w_count == (PW+1)'(W_FIFO_DEPTH));
  assign w_empty = (w_count == '0);
  assign w_head  = w_fifo[w_rd_ptr];
  assign w_pop   = m_w_valid && m_w_ready && m_w_last;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      w_fifo   <= '0;
      w_wr_ptr <= '0;
      w_rd_ptr <= '0;
      w_count  <= '0;
    end else begin
      if (aw_grant) begin
        w_fifo[w_wr_ptr] <= aw_win;
        w_wr_ptr         <= w_wr_ptr + 1'b1;
      end
      if (w_pop) w_rd_ptr <= w_rd_ptr + 1'b1;
      case ({aw_grant, w_pop})
        2'b10:   w_count <= w_count + 1'b1;
        2'b01:   w_count <= w_count - 1'b1;
        default: w_count <= w_count;
      endcase
    end
  end

  always_comb begin
    m_w_valid  = !w_empty && (w_head ? s1_w_valid : s0_w_valid);
    m_w_data   = w_head ? s1_w_data : s0_w_data;
    m_w_strb   = w_head ? s1_w_strb : s0_w_strb;
    m_w_last   = w_head ? s1_w_last : s0_w_last;
    s0_w_ready = !w_empty && !w_head && m_w_ready;
    s1_w_ready = !w_empty && w_head && m_w_ready;
  end

  // ---------------- B / R routing by downstream ID ----------------
  assign s0_b_valid = i_reset_n && m_b_valid && !m_b_id;
  assign s1_b_valid = i_reset_n && m_b_valid && m_b_id;
  assign s0_b_resp  = m_b_resp;
  assign s1_b_resp  = m_b_resp;
  assign m_b_ready  = m_b_id ? s1_b_ready : s0_b_ready;

  assign s0_r_valid = i_reset_n && m_r_valid && !m_r_id;
  assign s1_r_valid = i_reset_n && m_r_valid && m_r_id;
  assign s0_r_data  = m_r_data;
  assign s1_r_data  = m_r_data;
  assign s0_r_resp  = m_r_resp;
  assign s1_r_resp  = m_r_resp;
  assign s0_r_last  = m_r_last;
  assign s1_r_last  = m_r_last;
  assign m_r_ready  = m_r_id ? s1_r_ready : s0_r_ready;

endmodule
